// File: rtl/cla_pkg.sv
// Shared width, operand type and result bundle for the 4-bit carry-lookahead adder.
package cla_pkg;

    localparam int CLA_W = 4;

    typedef logic [CLA_W-1:0] nibble_t;

    typedef struct packed {
        nibble_t sum;
        logic    c4;
        logic    grp_p;
        logic    grp_g;
        logic    ovf;
    } cla_res_t;

endpackage

// File: rtl/cla_lookahead_4.sv
// Flat sum-of-products carry lookahead for one 4-bit group; no carry chain.
module cla_lookahead_4
    import cla_pkg::*;
(
    input  nibble_t          p,
    input  nibble_t          g,
    input  logic             c0,
    output logic [CLA_W:1]   c,
    output logic             grp_p,
    output logic             grp_g
);

    always_comb begin
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        // Group terms let wider adders cascade: c4 == grp_g | grp_p & c0.
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
    end

endmodule

// File: rtl/four_bit_cla_adder.sv
// Registered 4-bit CLA adder: a + b + c0 with carry-out, group P/G and signed overflow.
// Define FOUR_BIT_CLA_INPUT_REG_EN to register operands ahead of the lookahead (latency 2).
module four_bit_cla_adder
    import cla_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  nibble_t a,
    input  nibble_t b,
    input  logic    c0,
    output logic    out_valid,
    output nibble_t sum,
    output logic    c4,
    output logic    grp_p,
    output logic    grp_g,
    output logic    ovf
);

    // Valid-only stream: an operand set is accepted on every edge where in_valid=1;
    // there is no ready, so the producer is never stalled.
    nibble_t         a_s;
    nibble_t         b_s;
    logic            c0_s;
    logic            v_s;

`ifdef FOUR_BIT_CLA_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s  <= '0;
            b_s  <= '0;
            c0_s <= 1'b0;
            v_s  <= 1'b0;
        end else begin
            a_s  <= a;
            b_s  <= b;
            c0_s <= c0;
            v_s  <= in_valid;
        end
    end
`else
    assign a_s  = a;
    assign b_s  = b;
    assign c0_s = c0;
    assign v_s  = in_valid;
`endif

    nibble_t         p;
    nibble_t         g;
    logic [CLA_W:1]  c;
    logic            gp;
    logic            gg;
    cla_res_t        res_d;
    cla_res_t        res_q;
    logic            valid_q;

    assign p = a_s ^ b_s;
    assign g = a_s & b_s;

    cla_lookahead_4 u_lookahead (
        .p     (p),
        .g     (g),
        .c0    (c0_s),
        .c     (c),
        .grp_p (gp),
        .grp_g (gg)
    );

    always_comb begin
        res_d       = '0;
        res_d.sum   = p ^ {c[3:1], c0_s};
        res_d.c4    = c[4];
        res_d.grp_p = gp;
        res_d.grp_g = gg;
        res_d.ovf   = c[4] ^ c[3];
    end

    // Results hold across idle cycles; only out_valid tracks every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= v_s;
            if (v_s) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = res_q.sum;
    assign c4        = res_q.c4;
    assign grp_p     = res_q.grp_p;
    assign grp_g     = res_q.grp_g;
    assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_four_bit_cla_adder.sv
// Self-checking bench for four_bit_cla_adder: directed table, hold, async reset, random stream.
module tb_four_bit_cla_adder;

`ifdef FOUR_BIT_CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int W = 10;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic       out_valid;
    logic [3:0] sum;
    logic       c4;
    logic       grp_p;
    logic       grp_g;
    logic       ovf;

    four_bit_cla_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c0        (c0),
        .out_valid (out_valid),
        .sum       (sum),
        .c4        (c4),
        .grp_p     (grp_p),
        .grp_g     (grp_g),
        .ovf       (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // scoreboard: operand records in flight, {valid, a, b, c0}
    logic [W-1:0] exp_q[$];
    logic [8:0]   exp_vec;
    logic         last_c0;
    bit           have_res;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c0;
        logic [3:0] sum;
        logic       c4;
        logic       grp_p;
        logic       grp_g;
        logic       ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {out_valid, sum, c4, grp_p, grp_g, ovf};
    endfunction

    // reference: plain integer arithmetic
    function automatic logic [7:0] ref_res(input logic [3:0] ra, input logic [3:0] rb, input logic rc);
        int unsigned t;
        int          sa;
        int          sb;
        int          s;
        logic [3:0]  rs;
        logic        rc4;
        logic        rgp;
        logic        rgg;
        logic        rov;
        t   = int'(ra) + int'(rb) + int'(rc);
        rs  = t[3:0];
        rc4 = (t >= 16);
        rgp = ((ra ^ rb) == 4'hF);
        rgg = ((int'(ra) + int'(rb)) >= 16);
        sa  = (ra >= 8) ? int'(ra) - 16 : int'(ra);
        sb  = (rb >= 8) ? int'(rb) - 16 : int'(rb);
        s   = sa + sb + int'(rc);
        rov = (s > 7) || (s < -8);
        return {rs, rc4, rgp, rgg, rov};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
        exp_vec  = '0;
        have_res = 1'b0;
        last_c0  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        logic [W-1:0] rec;
        exp_q.push_back({v, ma, mb, mc});
        rec        = exp_q.pop_front();
        exp_vec[8] = rec[9];
        if (rec[9]) begin
            exp_vec[7:0] = ref_res(rec[8:5], rec[4:1], rec[0]);
            last_c0      = rec[0];
            have_res     = 1'b1;
        end
    endtask

    // driver: called at a negedge; drives, crosses one posedge, checks at the next negedge
    task automatic cycle(input logic v, input logic [3:0] ia, input logic [3:0] ib, input logic ic);
        in_valid = v;
        a        = ia;
        b        = ib;
        c0       = ic;
        @(posedge clk);
        model_step(v, ia, ib, ic);
        @(negedge clk);
        chk("result", 16'(dut_vec()), 16'(exp_vec));
        if (have_res) chk("cascade_identity", 16'(c4), 16'(grp_g | (grp_p & last_c0)));
    endtask

    int         perm[512];
    logic [8:0] x;

    initial begin
        tbl[0] = '{4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b0110, 4'b0101, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'b1111, 4'b1000, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c0       = 1'b0;
        model_reset();
        #2;
        chk("reset_outputs", 16'(dut_vec()), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 4'h0, 4'h0, 1'b0);
        chk("valid_low_after_reset", 16'(out_valid), 16'h0);

        // directed table; each row is followed by LAT-1 idle cycles so it reaches the outputs
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].c0);
            for (int k = 0; k < LAT - 1; k++) cycle(1'b0, 4'h0, 4'h0, 1'b0);
            chk($sformatf("table_%0d", i), 16'(dut_vec()),
                16'({1'b1, tbl[i].sum, tbl[i].c4, tbl[i].grp_p, tbl[i].grp_g, tbl[i].ovf}));
        end

        // last row stays on the outputs while in_valid is low
        cycle(1'b0, 4'h5, 4'h9, 1'b1);
        cycle(1'b0, 4'h3, 4'hC, 1'b0);
        chk("hold_when_idle", 16'(dut_vec()), 16'({1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0}));

        // reset between edges mid-stream
        cycle(1'b1, 4'h9, 4'h9, 1'b0);
        cycle(1'b1, 4'hA, 4'h7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_midstream", 16'(dut_vec()), 16'h0);
        @(posedge clk);
        #1;
        chk("reset_held_over_edge", 16'(dut_vec()), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 4'h0, 4'h0, 1'b0);
        chk("valid_low_after_rerelease", 16'(out_valid), 16'h0);

        // back-to-back stream over every {a,b,c0} in random order
        for (int i = 0; i < 512; i++) perm[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j       = int'($urandom_range(i, 0));
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            x = perm[i][8:0];
            cycle(1'b1, x[8:5], x[4:1], x[0]);
        end

        // random operands with random gaps
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                  4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
        end
        for (int k = 0; k < LAT; k++) cycle(1'b0, 4'h0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
